sweep_ctrl_amisha: RTL and testbench

SWEEP_CTRL_AMISHA -- requirements
Module: sweep_ctrl_amisha

---
 rtl/sweep_ctrl_amisha.sv | 123 ++++++++++++
 tb/tb_sweep_ctrl_amisha.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl_amisha.sv
// Sweep controller for an attached universal counter: clears, loads lo, then runs
// a programmable number of up/down sweeps between the latched lo and hi bounds.
module sweep_ctrl_amisha #(
    parameter int N = 8
) (
    input  logic         clk_amisha,
    input  logic         reset_amisha,
    input  logic         start_amisha,
    input  logic         abort_amisha,
    input  logic [N-1:0] lo_amisha,
    input  logic [N-1:0] hi_amisha,
    input  logic [3:0]   cycles_amisha,
    input  logic [N-1:0] q_amisha,
    output logic         syn_clr_amisha,
    output logic         load_amisha,
    output logic         en_amisha,
    output logic         up_amisha,
    output logic [N-1:0] d_amisha,
    output logic         busy_amisha,
    output logic         done_amisha,
    output logic         err_amisha,
    output logic [3:0]   sweeps_left_amisha
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLoad,
        StUp,
        StDown,
        StDone,
        StErr
    } state_t;

    state_t       state_q;
    logic [N-1:0] lo_q;
    logic [N-1:0] hi_q;
    logic [3:0]   sweeps_q;
    logic         err_q;

    logic active;
    logic kill;
    logic q_bad;
    logic start_ok;

    always_comb begin
        active   = (state_q == StClr) || (state_q == StLoad) || (state_q == StUp) ||
                   (state_q == StDown) || (state_q == StDone);
        kill     = abort_amisha && active;
        q_bad    = (q_amisha < lo_q) || (q_amisha > hi_q);
        start_ok = (lo_amisha < hi_amisha) && (cycles_amisha != 4'd0);
    end

    // Counter controls follow q in the same cycle, so they are decoded, not registered.
    always_comb begin
        syn_clr_amisha     = (state_q == StClr) && !kill;
        load_amisha        = (state_q == StLoad) && !kill;
        d_amisha           = (state_q == StLoad) ? lo_q : '0;
        up_amisha          = (state_q == StUp);
        en_amisha          = 1'b0;
        if (!kill && !q_bad) begin
            if (state_q == StUp) begin
                en_amisha = (q_amisha != hi_q);
            end else if (state_q == StDown) begin
                en_amisha = (q_amisha != lo_q);
            end
        end
        busy_amisha        = active;
        done_amisha        = (state_q == StDone) && !abort_amisha;
        err_amisha         = err_q;
        sweeps_left_amisha = sweeps_q;
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            sweeps_q <= 4'd0;
            err_q    <= 1'b0;
        end else if (kill) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle, StErr: begin
                    if (start_amisha) begin
                        if (start_ok) begin
                            lo_q     <= lo_amisha;
                            hi_q     <= hi_amisha;
                            sweeps_q <= cycles_amisha;
                            err_q    <= 1'b0;
                            state_q  <= StClr;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StClr:  state_q <= StLoad;
                StLoad: state_q <= StUp;
                StUp: begin
                    if (q_bad) begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else if (q_amisha == hi_q) begin
                        state_q <= StDown;
                    end
                end
                StDown: begin
                    if (q_bad) begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else if (q_amisha == lo_q) begin
                        sweeps_q <= sweeps_q - 4'd1;
                        state_q  <= (sweeps_q == 4'd1) ? StDone : StUp;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl_amisha.sv
// Directed bench for sweep_ctrl_amisha with a behavioural universal counter on q.
module tb_sweep_ctrl_amisha;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] lo, hi, q, d;
    logic [3:0] cycles, sl;
    logic       syn_clr, load, en, up, busy, done, err;

    logic [7:0] cnt;
    logic       qf_en;
    logic [7:0] qf_val;
    int         done_cnt = 0;
    int         total = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    sweep_ctrl_amisha #(.N(8)) dut (
        .clk_amisha        (clk),
        .reset_amisha      (reset),
        .start_amisha      (start),
        .abort_amisha      (abort),
        .lo_amisha         (lo),
        .hi_amisha         (hi),
        .cycles_amisha     (cycles),
        .q_amisha          (q),
        .syn_clr_amisha    (syn_clr),
        .load_amisha       (load),
        .en_amisha         (en),
        .up_amisha         (up),
        .d_amisha          (d),
        .busy_amisha       (busy),
        .done_amisha       (done),
        .err_amisha        (err),
        .sweeps_left_amisha(sl)
    );

    // Counter model: syn_clr > load > en.
    always_ff @(posedge clk) begin
        if (reset || syn_clr) cnt <= 8'd0;
        else if (load)        cnt <= d;
        else if (en)          cnt <= up ? cnt + 8'd1 : cnt - 8'd1;
    end
    assign q = qf_en ? qf_val : cnt;

    always @(posedge clk) if (done) done_cnt++;

    typedef struct {
        logic       start;
        logic       sc, ld, en, up;
        logic [7:0] d;
        logic       busy, done, err;
        logic [3:0] sl;
        logic [7:0] q;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] obs();
        return {5'd0, syn_clr, load, en, up, d, busy, done, err, sl, q};
    endfunction

    function automatic logic [31:0] mk(vec_t v);
        return {5'd0, v.sc, v.ld, v.en, v.up, v.d, v.busy, v.done, v.err, v.sl, v.q};
    endfunction

    function automatic vec_t vv(logic st, logic sc_, logic ld_, logic en_, logic up_,
                                logic [7:0] d_, logic bz, logic dn, logic er,
                                logic [3:0] sl_, logic [7:0] q_);
        vec_t v;
        v.start = st; v.sc = sc_; v.ld = ld_; v.en = en_; v.up = up_; v.d = d_;
        v.busy = bz; v.done = dn; v.err = er; v.sl = sl_; v.q = q_;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle; returns positioned in T1.
    task automatic start_job(input logic [7:0] l, input logic [7:0] h, input logic [3:0] c);
        lo = l; hi = h; cycles = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int snap;
        int t;
        int seen;
        reset = 1'b1; start = 1'b0; abort = 1'b0; lo = 8'd0; hi = 8'd0; cycles = 4'd0;
        qf_en = 1'b0; qf_val = 8'd0;
        step(); step();
        reset = 1'b0;
        chk("reset_state", obs(), 32'd0);

        // Basic sweep lo=3 hi=6 cycles=1; start at T4 must be ignored.
        vecs[0]  = vv(0, 1, 0, 0, 0, 8'd0, 1, 0, 0, 4'd1, 8'd0);
        vecs[1]  = vv(0, 0, 1, 0, 0, 8'd3, 1, 0, 0, 4'd1, 8'd0);
        vecs[2]  = vv(0, 0, 0, 1, 1, 8'd0, 1, 0, 0, 4'd1, 8'd3);
        vecs[3]  = vv(1, 0, 0, 1, 1, 8'd0, 1, 0, 0, 4'd1, 8'd4);
        vecs[4]  = vv(0, 0, 0, 1, 1, 8'd0, 1, 0, 0, 4'd1, 8'd5);
        vecs[5]  = vv(0, 0, 0, 0, 1, 8'd0, 1, 0, 0, 4'd1, 8'd6);
        vecs[6]  = vv(0, 0, 0, 1, 0, 8'd0, 1, 0, 0, 4'd1, 8'd6);
        vecs[7]  = vv(0, 0, 0, 1, 0, 8'd0, 1, 0, 0, 4'd1, 8'd5);
        vecs[8]  = vv(0, 0, 0, 1, 0, 8'd0, 1, 0, 0, 4'd1, 8'd4);
        vecs[9]  = vv(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 4'd1, 8'd3);
        vecs[10] = vv(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 4'd0, 8'd3);
        vecs[11] = vv(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 4'd0, 8'd3);
        start_job(8'd3, 8'd6, 4'd1);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].start) begin
                start = 1'b1; lo = 8'd0; hi = 8'd1; cycles = 4'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            chk($sformatf("basic_T%0d", i + 1), obs(), mk(vecs[i]));
            step();
        end
        start = 1'b0;

        // Multi-sweep lo=0 hi=2 cycles=2: single done at T15.
        snap = done_cnt;
        start_job(8'd0, 8'd2, 4'd2);
        for (t = 1; t <= 16; t++) begin
            if (t == 8)  chk("multi_sl_T8", {28'd0, sl}, 32'd2);
            if (t == 9)  chk("multi_sl_T9", {28'd0, sl}, 32'd1);
            if (t == 14) chk("multi_nodone_T14", {31'd0, done}, 32'd0);
            if (t == 15) chk("multi_done_T15", {27'd0, done, sl}, {27'd0, 1'b1, 4'd0});
            if (t == 16) chk("multi_idle_T16", {31'd0, busy}, 32'd0);
            step();
        end
        chk("multi_done_count", done_cnt - snap, 32'd1);

        // Bad configurations, then a valid start clears err.
        start_job(8'd9, 8'd9, 4'd1);
        chk("bad_lohi", {28'd0, err, busy, syn_clr, load | en}, {28'd0, 4'b1000});
        start_job(8'd1, 8'd5, 4'd0);
        chk("bad_cycles", {28'd0, err, busy, syn_clr, load | en}, {28'd0, 4'b1000});
        start_job(8'd1, 8'd2, 4'd1);
        chk("good_clears_err", {29'd0, err, busy, syn_clr}, {29'd0, 3'b011});
        seen = 0;
        for (t = 1; t <= 40 && seen == 0; t++) begin
            if (done) seen = t;
            else step();
        end
        chk("good_job_len", seen, 32'd7);
        step(); step();

        // Abort in UP at q=4.
        snap = done_cnt;
        start_job(8'd3, 8'd6, 4'd2);
        step(); step(); step();
        chk("abort_pre", {23'd0, up, en, q}, {23'd0, 1'b1, 1'b1, 8'd4});
        abort = 1'b1;
        #1;
        chk("abort_en0", {29'd0, syn_clr, load, en}, 32'd0);
        step();
        abort = 1'b0;
        chk("abort_idle", {25'd0, busy, syn_clr, load, en, up, done, err},
            32'd0);
        chk("abort_sl", {28'd0, sl}, 32'd2);
        for (int i = 0; i < 20; i++) step();
        chk("abort_nodone", done_cnt - snap, 32'd0);

        // Range fault: q forced to 200 in UP.
        start_job(8'd3, 8'd6, 4'd1);
        step(); step(); step();
        qf_val = 8'd200; qf_en = 1'b1;
        #1;
        chk("fault_en0", {31'd0, en}, 32'd0);
        step();
        qf_en = 1'b0;
        chk("fault_err", {27'd0, err, busy, syn_clr, load, en}, {27'd0, 5'b10000});
        step();
        chk("fault_sticky", {30'd0, err, busy}, {30'd0, 2'b10});
        start_job(8'd3, 8'd6, 4'd1);
        chk("err_restart", {29'd0, err, busy, syn_clr}, {29'd0, 3'b011});

        // Reset mid-DOWN.
        for (int i = 0; i < 6; i++) step();
        chk("down_pre", {30'd0, up, en}, {30'd0, 2'b01});
        snap = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_mid", obs(), 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("reset_nodone", done_cnt - snap, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
